// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin sharing of the single L2 port between L1I and L1D,
// one registered transaction at a time, with saturating grant counters for debug.
module l2_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  read_L1I_L2,
    input  logic [ADDR_WIDTH-1:0] address_L1I_L2,
    output logic                  ready_L2_L1I,
    output logic [LINE_WIDTH-1:0] read_data_L2_L1I,
    input  logic                  read_L1D_L2,
    input  logic                  write_L1D_L2,
    input  logic [ADDR_WIDTH-1:0] address_L1D_L2,
    input  logic [LINE_WIDTH-1:0] write_data_L1D_L2,
    output logic                  ready_L2_L1D,
    output logic [LINE_WIDTH-1:0] read_data_L2_L1D,
    output logic                  read_ARB_L2,
    output logic                  write_ARB_L2,
    output logic [ADDR_WIDTH-1:0] address_ARB_L2,
    output logic [LINE_WIDTH-1:0] write_data_ARB_L2,
    input  logic                  ready_L2_ARB,
    input  logic [LINE_WIDTH-1:0] read_data_L2_ARB,
    output logic [1:0]            grant_state,
    output logic [CNT_WIDTH-1:0]  count_L1I,
    output logic [CNT_WIDTH-1:0]  count_L1D
);
    localparam logic [1:0] IDLE = 2'b00, REQ = 2'b01, RESP = 2'b10;
    logic [1:0] state;
    logic       owner;
    logic       last_grant;
    logic       pend_i, pend_d, pick_d, wr_d;
    // owner/last_grant: 0 = L1I, 1 = L1D; reset leaves last_grant on L1D so L1I wins the first tie
    always_comb begin
        pend_i = read_L1I_L2;
        pend_d = read_L1D_L2 | write_L1D_L2;
        pick_d = pend_d & (~pend_i | ~last_grant);
        wr_d   = pick_d & write_L1D_L2;
        grant_state = (state == IDLE) ? 2'b00 : (state == RESP) ? 2'b11 : owner ? 2'b10 : 2'b01;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            owner             <= 1'b0;
            last_grant        <= 1'b1;
            read_ARB_L2       <= 1'b0;
            write_ARB_L2      <= 1'b0;
            address_ARB_L2    <= '0;
            write_data_ARB_L2 <= '0;
            ready_L2_L1I      <= 1'b0;
            ready_L2_L1D      <= 1'b0;
            read_data_L2_L1I  <= '0;
            read_data_L2_L1D  <= '0;
            count_L1I         <= '0;
            count_L1D         <= '0;
        end else begin
            ready_L2_L1I <= 1'b0;
            ready_L2_L1D <= 1'b0;
            case (state)
                IDLE: if (pend_i | pend_d) begin
                    state          <= REQ;
                    owner          <= pick_d;
                    last_grant     <= pick_d;
                    address_ARB_L2 <= pick_d ? address_L1D_L2 : address_L1I_L2;
                    read_ARB_L2    <= ~wr_d;
                    write_ARB_L2   <= wr_d;
                    if (wr_d) write_data_ARB_L2 <= write_data_L1D_L2;
                end
                REQ: if (ready_L2_ARB) begin
                    state        <= RESP;
                    read_ARB_L2  <= 1'b0;
                    write_ARB_L2 <= 1'b0;
                    ready_L2_L1I <= ~owner;
                    ready_L2_L1D <= owner;
                    if (read_ARB_L2 && owner) read_data_L2_L1D <= read_data_L2_ARB;
                    if (read_ARB_L2 && !owner) read_data_L2_L1I <= read_data_L2_ARB;
                end
                RESP: begin
                    state <= IDLE;
                    if (!owner && !(&count_L1I)) count_L1I <= count_L1I + 1'b1;
                    if (owner && !(&count_L1D)) count_L1D <= count_L1D + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed checks of arbitration order, L2 handshake, reset abort and
// counter saturation (a second instance with 2-bit counters shares all inputs).
`timescale 1ns/1ps
module tb_l2_port_arbiter;
    localparam int AW = 32, LW = 128;
    logic          clk = 1'b0, rstn = 1'b0;
    logic          read_L1I_L2 = 0, read_L1D_L2 = 0, write_L1D_L2 = 0, ready_L2_ARB = 0;
    logic [AW-1:0] address_L1I_L2 = '0, address_L1D_L2 = '0;
    logic [LW-1:0] write_data_L1D_L2 = '0, read_data_L2_ARB = '0;
    logic          ready_L2_L1I, ready_L2_L1D, read_ARB_L2, write_ARB_L2;
    logic [LW-1:0] read_data_L2_L1I, read_data_L2_L1D, write_data_ARB_L2;
    logic [AW-1:0] address_ARB_L2;
    logic [1:0]    grant_state;
    logic [15:0]   count_L1I, count_L1D;
    logic          s_rdy_i, s_rdy_d, s_rd, s_wr;
    logic [LW-1:0] s_rdata_i, s_rdata_d, s_wdata;
    logic [AW-1:0] s_addr;
    logic [1:0]    s_state;
    logic [1:0]    s_cnt_i, s_cnt_d;
    int n_cmp = 0, n_err = 0;
    localparam logic [LW-1:0] LINE1 = {32{4'h1}}, LINE_A = {32{4'hA}}, LINE_B = {32{4'hB}};
    localparam logic [LW-1:0] LINE_C = {32{4'hC}}, LINE_5 = {32{4'h5}};
    localparam logic [LW-1:0] WDATA = 128'hDEAD0000_01234567_89ABCDEF_0000BEEF;
    localparam logic [LW-1:0] WDATA2 = 128'h0F0F0F0F_00000000_12345678_9ABCDEF0;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk(clk), .rstn(rstn),
        .read_L1I_L2(read_L1I_L2), .address_L1I_L2(address_L1I_L2),
        .ready_L2_L1I(ready_L2_L1I), .read_data_L2_L1I(read_data_L2_L1I),
        .read_L1D_L2(read_L1D_L2), .write_L1D_L2(write_L1D_L2),
        .address_L1D_L2(address_L1D_L2), .write_data_L1D_L2(write_data_L1D_L2),
        .ready_L2_L1D(ready_L2_L1D), .read_data_L2_L1D(read_data_L2_L1D),
        .read_ARB_L2(read_ARB_L2), .write_ARB_L2(write_ARB_L2),
        .address_ARB_L2(address_ARB_L2), .write_data_ARB_L2(write_data_ARB_L2),
        .ready_L2_ARB(ready_L2_ARB), .read_data_L2_ARB(read_data_L2_ARB),
        .grant_state(grant_state), .count_L1I(count_L1I), .count_L1D(count_L1D)
    );

    l2_port_arbiter #(.CNT_WIDTH(2)) sat (
        .clk(clk), .rstn(rstn),
        .read_L1I_L2(read_L1I_L2), .address_L1I_L2(address_L1I_L2),
        .ready_L2_L1I(s_rdy_i), .read_data_L2_L1I(s_rdata_i),
        .read_L1D_L2(read_L1D_L2), .write_L1D_L2(write_L1D_L2),
        .address_L1D_L2(address_L1D_L2), .write_data_L1D_L2(write_data_L1D_L2),
        .ready_L2_L1D(s_rdy_d), .read_data_L2_L1D(s_rdata_d),
        .read_ARB_L2(s_rd), .write_ARB_L2(s_wr),
        .address_ARB_L2(s_addr), .write_data_ARB_L2(s_wdata),
        .ready_L2_ARB(ready_L2_ARB), .read_data_L2_ARB(read_data_L2_ARB),
        .grant_state(s_state), .count_L1I(s_cnt_i), .count_L1D(s_cnt_d)
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called in a REQ cycle; returns in the RESP cycle
    task automatic serve(input logic [LW-1:0] line, input int dly);
        for (int i = 0; i < dly; i++) tick();
        ready_L2_ARB = 1'b1;
        read_data_L2_ARB = line;
        tick();
        ready_L2_ARB = 1'b0;
        read_data_L2_ARB = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_state", grant_state, 0);
        check("rst_rd", read_ARB_L2, 0);
        check("rst_wr", write_ARB_L2, 0);
        check("rst_addr", address_ARB_L2, 0);
        check("rst_rdy", {ready_L2_L1I, ready_L2_L1D}, 0);
        check("rst_cnt", {count_L1I, count_L1D}, 0);
        check("rst_rdata_i", read_data_L2_L1I, 0);

        // single L1I read, L2 answers in the second REQ cycle
        read_L1I_L2 = 1; address_L1I_L2 = 32'h40;
        tick();
        check("t1_rd", read_ARB_L2, 1);
        check("t1_wr", write_ARB_L2, 0);
        check("t1_addr", address_ARB_L2, 32'h40);
        check("t1_state", grant_state, 2'b01);
        serve(LINE1, 1);
        check("t1_rdy_i", ready_L2_L1I, 1);
        check("t1_rdy_d", ready_L2_L1D, 0);
        check("t1_line", read_data_L2_L1I, LINE1);
        check("t1_resp", grant_state, 2'b11);
        check("t1_rd_drop", read_ARB_L2, 0);
        read_L1I_L2 = 0;
        tick();
        check("t1_rdy_pulse", ready_L2_L1I, 0);
        check("t1_idle", grant_state, 2'b00);
        check("t1_cnt", count_L1I, 1);

        // simultaneous requests from reset: L1I first, then L1D
        do_reset();
        read_L1I_L2 = 1; address_L1I_L2 = 32'h80;
        read_L1D_L2 = 1; address_L1D_L2 = 32'h200;
        tick();
        check("t2_first", grant_state, 2'b01);
        check("t2_addr_i", address_ARB_L2, 32'h80);
        serve(LINE_A, 0);
        check("t2_rdy_i", {ready_L2_L1I, ready_L2_L1D}, 2'b10);
        read_L1I_L2 = 0;
        tick();
        tick();
        check("t2_second", grant_state, 2'b10);
        check("t2_addr_d", address_ARB_L2, 32'h200);
        serve(LINE_B, 1);
        check("t2_rdy_d", {ready_L2_L1I, ready_L2_L1D}, 2'b01);
        check("t2_line_d", read_data_L2_L1D, LINE_B);
        check("t2_line_i", read_data_L2_L1I, LINE_A);
        read_L1D_L2 = 0;
        tick();
        // second pair: last grant was L1D, so L1I wins again
        read_L1I_L2 = 1; read_L1D_L2 = 1;
        tick();
        check("t2b_first", grant_state, 2'b01);
        serve(LINE_C, 0);
        read_L1I_L2 = 0;
        tick();
        tick();
        check("t2b_second", grant_state, 2'b10);
        serve(LINE_C, 0);
        read_L1D_L2 = 0;
        tick();
        check("t2_cnt", {count_L1I, count_L1D}, {16'd2, 16'd2});

        // L1D writeback
        write_L1D_L2 = 1; address_L1D_L2 = 32'h100; write_data_L1D_L2 = WDATA;
        tick();
        check("t3_wr", write_ARB_L2, 1);
        check("t3_rd", read_ARB_L2, 0);
        check("t3_addr", address_ARB_L2, 32'h100);
        check("t3_wdata", write_data_ARB_L2, WDATA);
        serve(LINE_5, 2);
        check("t3_rdy_d", ready_L2_L1D, 1);
        check("t3_keep", read_data_L2_L1D, LINE_C);
        write_L1D_L2 = 0;
        tick();

        // read and write together: the write wins
        read_L1D_L2 = 1; write_L1D_L2 = 1; write_data_L1D_L2 = WDATA2;
        tick();
        check("t4_rw", {read_ARB_L2, write_ARB_L2}, 2'b01);
        check("t4_wdata", write_data_ARB_L2, WDATA2);
        serve(LINE_5, 0);
        check("t4_keep", read_data_L2_L1D, LINE_C);
        read_L1D_L2 = 0; write_L1D_L2 = 0;
        tick();
        check("t4_cnt", count_L1D, 4);

        // reset during REQ, request held across it
        read_L1I_L2 = 1; address_L1I_L2 = 32'h300;
        tick();
        check("t5_req", read_ARB_L2, 1);
        rstn = 0;
        #1;
        check("t5_rd_drop", read_ARB_L2, 0);
        check("t5_state", grant_state, 0);
        check("t5_cnt", {count_L1I, count_L1D}, 0);
        tick();
        check("t5_no_rdy", {ready_L2_L1I, ready_L2_L1D}, 0);
        rstn = 1;
        tick();
        check("t5_regrant", grant_state, 2'b01);
        check("t5_addr", address_ARB_L2, 32'h300);
        serve(LINE_A, 0);
        check("t5_rdy", ready_L2_L1I, 1);
        read_L1I_L2 = 0;
        tick();
        check("t5_cnt1", count_L1I, 1);

        // stray L2 ready in IDLE is ignored
        ready_L2_ARB = 1;
        tick();
        ready_L2_ARB = 0;
        check("t6_norq", {ready_L2_L1I, ready_L2_L1D, grant_state}, 0);
        tick();
        check("t6_norq2", {ready_L2_L1I, ready_L2_L1D, grant_state}, 0);

        // saturation on the 2-bit instance: 1 + 4 transactions stays at 3
        for (int k = 0; k < 4; k++) begin
            read_L1I_L2 = 1;
            tick();
            serve(LINE_B, 0);
            read_L1I_L2 = 0;
            tick();
            if (k == 1) check("sat_reach", s_cnt_i, 3);
        end
        check("sat_hold", s_cnt_i, 3);
        check("sat_wide", count_L1I, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
